// File: rtl/alu_op_sequencer.sv
// Control stage for the 32-bit ALU datapath: accepts one request, drives one-hot
// datapath controls for a fixed number of cycles, then registers result and flags.
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int MUL_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        arithmic_op,
  output logic        sub,
  output logic        logic_op,
  output logic        shift_op,
  output logic        shift_right,
  output logic        mul_op,
  output logic        trans_op,
  output logic        trans_sel,
  output logic [1:0]  sel,
  input  logic [31:0] Y,
  input  logic        carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_PASSA = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       arith;
    logic       sub;
    logic       logic_op;
    logic [1:0] sel;
    logic       shift;
    logic       shift_right;
    logic       mul;
    logic       trans;
    logic       trans_sel;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  ctrl_t       ctrl_q, ctrl_d;
  ctrl_t       dec_ctrl;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_v_q, flag_v_d;
  logic        illegal_q, illegal_d;

  logic        is_add, is_sub, is_illegal;
  logic [31:0] y_cap;

  always_comb begin
    dec_ctrl = '0;
    case (op)
      OP_ADD:   dec_ctrl.arith = 1'b1;
      OP_SUB:   begin dec_ctrl.arith = 1'b1; dec_ctrl.sub = 1'b1; end
      OP_AND:   begin dec_ctrl.logic_op = 1'b1; dec_ctrl.sel = 2'b00; end
      OP_OR:    begin dec_ctrl.logic_op = 1'b1; dec_ctrl.sel = 2'b01; end
      OP_XOR:   begin dec_ctrl.logic_op = 1'b1; dec_ctrl.sel = 2'b10; end
      OP_NOR:   begin dec_ctrl.logic_op = 1'b1; dec_ctrl.sel = 2'b11; end
      OP_SHL:   dec_ctrl.shift = 1'b1;
      OP_SHR:   begin dec_ctrl.shift = 1'b1; dec_ctrl.shift_right = 1'b1; end
      OP_MUL:   dec_ctrl.mul = 1'b1;
      OP_PASSA: dec_ctrl.trans = 1'b1;
      OP_PASSB: begin dec_ctrl.trans = 1'b1; dec_ctrl.trans_sel = 1'b1; end
      default:  dec_ctrl = '0;
    endcase
  end

  // Flags are derived from the opcode latched at accept, not the live op input.
  assign is_add     = (op_q == OP_ADD);
  assign is_sub     = (op_q == OP_SUB);
  assign is_illegal = (op_q > OP_PASSB);
  assign y_cap      = is_illegal ? 32'd0 : Y;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    flag_v_d    = flag_v_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = op;
          ctrl_d  = dec_ctrl;
          cnt_d   = (op == OP_MUL) ? MUL_LOAD : EXEC_LOAD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d    = y_cap;
          flag_z_d    = (y_cap == 32'd0);
          flag_n_d    = y_cap[31];
          flag_c_d    = (is_add | is_sub) & carry;
          flag_v_d    = (is_add & (a_q[31] == b_q[31]) & (Y[31] != a_q[31])) |
                        (is_sub & (a_q[31] != b_q[31]) & (Y[31] != a_q[31]));
          illegal_d   = is_illegal;
          ctrl_d      = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_v_q    <= flag_v_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign A           = a_q;
  assign B           = b_q;
  assign arithmic_op = ctrl_q.arith;
  assign sub         = ctrl_q.sub;
  assign logic_op    = ctrl_q.logic_op;
  assign sel         = ctrl_q.sel;
  assign shift_op    = ctrl_q.shift;
  assign shift_right = ctrl_q.shift_right;
  assign mul_op      = ctrl_q.mul;
  assign trans_op    = ctrl_q.trans;
  assign trans_sel   = ctrl_q.trans_sel;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign flag_v      = flag_v_q;
  assign illegal     = illegal_q;

endmodule
